// File: rtl/sd_pkg.sv
// sd_pkg: shared FSM states, frame bit constants and CRC7 helper for the SD command controller
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CRC,
        SEND,
        WAIT_RESP,
        DONE
    } state_t;

    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam logic       START_BIT = 1'b0;
    localparam logic       TX_BIT    = 1'b1;
    localparam logic       END_BIT   = 1'b1;

    // One MSB-first step of the CRC7 LFSR (x^7 + x^3 + 1)
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_cmd_ctrl_param_if.sv
// sd_cmd_ctrl_param_if: host request, phy handshake and status bundle of the SD command controller
interface sd_cmd_ctrl_param_if #(
    parameter int IDX_W  = 6,
    parameter int ARG_W  = 32,
    parameter int RESP_W = 38
);
    localparam int FRAME_W = IDX_W + ARG_W + 10;

    logic               iNew_command;
    logic [IDX_W-1:0]   iCmd_index;
    logic [ARG_W-1:0]   iCmd_argument;
    logic               iResp_expected;
    logic               oIdle_out;
    logic               oStrobe_out;
    logic [FRAME_W-1:0] oCmd_frame;
    logic               iAck_in;
    logic               iStrobe_in;
    logic [RESP_W-1:0]  iResponse;
    logic               oAck_out;
    logic               oCommand_complete;
    logic               oTimeout;
    logic [RESP_W-1:0]  oResponse;

    modport master (
        output iNew_command, iCmd_index, iCmd_argument, iResp_expected,
               iAck_in, iStrobe_in, iResponse,
        input  oIdle_out, oStrobe_out, oCmd_frame, oAck_out,
               oCommand_complete, oTimeout, oResponse
    );

    modport slave (
        input  iNew_command, iCmd_index, iCmd_argument, iResp_expected,
               iAck_in, iStrobe_in, iResponse,
        output oIdle_out, oStrobe_out, oCmd_frame, oAck_out,
               oCommand_complete, oTimeout, oResponse
    );

endinterface

// File: rtl/sd_crc7_serial.sv
// sd_crc7_serial: bit-serial CRC7 accumulator, one frame bit per enabled cycle, MSB first
module sd_crc7_serial
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);
    logic [6:0] crc_q, crc_d;

    // Clear wins over a shift so every new frame starts from zero
    always_comb crc_d = clr ? 7'h00 : (en ? crc7_step(crc_q, din) : crc_q);

    // CRC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= 7'h00;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_ctrl_param.sv
// sd_cmd_ctrl_param: SD host command controller; builds the command frame, hands it to the phy
// and optionally waits (bounded) for a response. Define CMD_CRC_EN to compute the CRC7 field;
// without it the CRC stage is removed and the field is sent as all ones.
module sd_cmd_ctrl_param
    import sd_pkg::*;
#(
    parameter int IDX_W   = 6,
    parameter int ARG_W   = 32,
    parameter int RESP_W  = 38,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 64
) (
    input logic               iClock_host,
    input logic               iReset,
    sd_cmd_ctrl_param_if.slave bus
);
    localparam int FRAME_W = IDX_W + ARG_W + 10;
    localparam int PRE_W   = IDX_W + ARG_W + 2;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                end_q, end_d;
    logic                resp_exp_q, resp_exp_d;
    logic                to_flag_q, to_flag_d;
    logic                ack_q, ack_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic [6:0]          crc;
    logic [FRAME_W-1:0]  frame;
    logic                accept;

    assign accept = (state_q == IDLE) && bus.iNew_command;

`ifdef CMD_CRC_EN
    localparam int CNT_W = $clog2(PRE_W);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] sh_q, sh_d;

    sd_crc7_serial u_crc (
        .clk (iClock_host),
        .rst (iReset),
        .clr (accept),
        .en  (state_q == CRC),
        .din (sh_q[PRE_W-1]),
        .crc (crc)
    );

    // Prefix shifter feeding the CRC MSB first, with a bit counter that ends the CRC stage
    always_comb begin
        cnt_d = (state_q == CRC) ? cnt_q + 1'b1 : '0;
        sh_d  = accept ? {START_BIT, TX_BIT, bus.iCmd_index, bus.iCmd_argument}
                       : ((state_q == CRC) ? {sh_q[PRE_W-2:0], 1'b0} : sh_q);
    end

    // CRC stage registers
    always_ff @(posedge iClock_host or posedge iReset) begin
        if (iReset) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end
`else
    // No CRC stage: the field is all ones once a frame has been built, zero out of reset
    assign crc = end_q ? 7'h7F : 7'h00;
`endif

    // Next state, latched command fields, timeout counter and response capture
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        end_d      = end_q;
        resp_exp_d = resp_exp_q;
        to_flag_d  = to_flag_q;
        ack_d      = 1'b0;
        to_d       = to_q;
        resp_d     = resp_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pre_d      = {START_BIT, TX_BIT, bus.iCmd_index, bus.iCmd_argument};
                    end_d      = END_BIT;
                    resp_exp_d = bus.iResp_expected;
                    to_flag_d  = 1'b0;
`ifdef CMD_CRC_EN
                    state_d    = CRC;
`else
                    state_d    = SEND;
`endif
                end
            end
`ifdef CMD_CRC_EN
            CRC: begin
                if (cnt_q == CNT_W'(PRE_W - 1)) state_d = SEND;
            end
`endif
            SEND: begin
                if (bus.iAck_in) begin
                    state_d = resp_exp_q ? WAIT_RESP : DONE;
                    to_d    = '0;
                end
            end
            WAIT_RESP: begin
                if (bus.iStrobe_in) begin
                    resp_d  = bus.iResponse;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    to_flag_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge iClock_host or posedge iReset) begin
        if (iReset) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            end_q      <= 1'b0;
            resp_exp_q <= 1'b0;
            to_flag_q  <= 1'b0;
            ack_q      <= 1'b0;
            to_q       <= '0;
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            end_q      <= end_d;
            resp_exp_q <= resp_exp_d;
            to_flag_q  <= to_flag_d;
            ack_q      <= ack_d;
            to_q       <= to_d;
            resp_q     <= resp_d;
        end
    end

    assign frame                 = {pre_q, crc, end_q};
    assign bus.oCmd_frame        = frame;
    assign bus.oIdle_out         = (state_q == IDLE);
    assign bus.oStrobe_out       = (state_q == SEND);
    assign bus.oCommand_complete = (state_q == DONE);
    assign bus.oAck_out          = ack_q;
    assign bus.oTimeout          = to_flag_q;
    assign bus.oResponse         = resp_q;

endmodule
